vx_gbar_unit: RTL

Global barrier unit at cluster level, downstream of each socket's `gbar_bus_if` arbiter output. It collects barrier arrivals from all cores in the cluster and tracks an arrival set per barrier ID. When the last expected core arrives, it broadcasts a one-cycle release carrying the barrier ID back to every socket. It also reports occupancy, protocol errors and a release counter.

---
 rtl/vx_gbar_unit.sv | 113 +++++++++++
 1 files changed

// File: rtl/vx_gbar_unit.sv
// Cluster-level global barrier unit: tracks per-barrier arrival sets from all
// cores and broadcasts a one-cycle release when a barrier's last core arrives.
module vx_gbar_unit #(
  parameter int    NUM_BARRIERS = 8,
  parameter int    NUM_CORES    = 4,
  parameter string INSTANCE_ID  = "",
  localparam int   NB_W         = $clog2(NUM_BARRIERS),
  localparam int   CID_W        = $clog2(NUM_CORES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [NB_W-1:0]  req_id,
  input  logic [CID_W-1:0] req_size_m1,
  input  logic [CID_W-1:0] req_core_id,
  output logic             req_ready,
  output logic             rsp_valid,
  output logic [NB_W-1:0]  rsp_id,
  output logic             busy,
  output logic             err_dup,
  output logic             err_size,
  output logic [31:0]      perf_releases
);

  if ((NUM_BARRIERS < 2) || ((NUM_BARRIERS & (NUM_BARRIERS - 1)) != 0) ||
      (NUM_CORES < 2) || ((NUM_CORES & (NUM_CORES - 1)) != 0)) begin : g_param_check
    $error("vx_gbar_unit %s: NUM_BARRIERS and NUM_CORES must be powers of two >= 2",
           INSTANCE_ID);
  end

  logic [NUM_CORES-1:0] mask_q [NUM_BARRIERS];
  logic [CID_W-1:0]     size_q [NUM_BARRIERS];

  logic [NUM_BARRIERS-1:0] active;
  logic [NUM_CORES-1:0]    cur_mask;
  logic [NUM_CORES-1:0]    core_bit;
  logic [NUM_CORES-1:0]    new_mask;
  logic                    cur_active;
  logic [CID_W-1:0]        eff_size;
  logic                    fire;
  logic                    is_dup;
  logic                    size_bad;
  logic                    done;

  function automatic logic [CID_W:0] popcount(input logic [NUM_CORES-1:0] v);
    logic [CID_W:0] n;
    n = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      n = n + {{CID_W{1'b0}}, v[i]};
    end
    return n;
  endfunction

  always_comb begin
    active = '0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      active[b] = |mask_q[b];
    end
  end

  assign busy = |active;
  assign fire = req_valid & req_ready;

  // Decode of the single incoming arrival against its barrier's state.
  always_comb begin
    cur_mask   = mask_q[req_id];
    cur_active = active[req_id];
    core_bit   = NUM_CORES'(1) << req_core_id;
    new_mask   = cur_mask | core_bit;
    eff_size   = cur_active ? size_q[req_id] : req_size_m1;
    is_dup     = |(cur_mask & core_bit);
    size_bad   = cur_active && (req_size_m1 != size_q[req_id]);
    done       = (popcount(new_mask) == ({1'b0, eff_size} + 1'b1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      err_dup       <= 1'b0;
      err_size      <= 1'b0;
      perf_releases <= '0;
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        mask_q[b] <= '0;
        size_q[b] <= '0;
      end
    end else begin
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      if (fire) begin
        if (!cur_active) begin
          size_q[req_id] <= req_size_m1;
        end
        if (size_bad) begin
          err_size <= 1'b1;
        end
        if (is_dup) begin
          err_dup <= 1'b1;
        end else if (done) begin
          // Release also covers size_m1==0: mask is cleared, never set.
          mask_q[req_id] <= '0;
          rsp_valid      <= 1'b1;
          rsp_id         <= req_id;
          perf_releases  <= perf_releases + 32'd1;
        end else begin
          mask_q[req_id] <= new_mask;
        end
      end
    end
  end

endmodule
